// File: rtl/motor_duty_ramp.sv
// rtl/motor_duty_ramp.sv - soft-start/soft-reverse duty ramp ahead of the motor PWM controller
// Reversals always ramp duty to zero before the direction bit is allowed to change.
module motor_duty_ramp #(
   parameter int PERIOD   = 2777,
   parameter int WIDTH    = 12,
   parameter int STEP     = 16,
   parameter int TICK_DIV = 5000
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_duty,
   input  logic             estop,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] duty_period,
   output logic             dir,
   output logic             enable,
   output logic             at_target
);

   localparam int               CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]    TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] PERIOD_W  = WIDTH'(PERIOD);
   localparam logic [WIDTH:0]   STEP_X    = (WIDTH + 1)'(STEP);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RAMP,
      S_REVERSE,
      S_ESTOP
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] tgt_duty_q, tgt_duty_d;
   logic             tgt_dir_q, tgt_dir_d;
   logic             enable_q, enable_d;

   logic             tick;
   logic             accept;
   logic [WIDTH-1:0] cmd_duty_clamped;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   mag;
   logic [WIDTH-1:0] ramp_amt;
   logic [WIDTH-1:0] ramp_next;
   logic [WIDTH-1:0] down_amt;

   assign cmd_ready   = (state_q != S_ESTOP);
   assign at_target   = (state_q == S_IDLE);
   assign period      = PERIOD_W;
   assign duty_period = duty_q;
   assign dir         = dir_q;
   assign enable      = enable_q;

   always_comb begin
      tick             = (tick_cnt_q == TICK_LAST);
      tick_cnt_d       = tick ? '0 : tick_cnt_q + CW'(1);
      accept           = cmd_valid && cmd_ready;
      cmd_duty_clamped = (cmd_duty > PERIOD_W) ? PERIOD_W : cmd_duty;

      // Signed distance to target at one extra bit so both directions share one magnitude path.
      diff      = {1'b0, tgt_duty_q} - {1'b0, duty_q};
      mag       = diff[WIDTH] ? (~diff + 1'b1) : diff;
      ramp_amt  = (mag > STEP_X) ? STEP_X[WIDTH-1:0] : mag[WIDTH-1:0];
      ramp_next = diff[WIDTH] ? (duty_q - ramp_amt) : (duty_q + ramp_amt);
      down_amt  = ({1'b0, duty_q} > STEP_X) ? STEP_X[WIDTH-1:0] : duty_q;

      state_d    = state_q;
      duty_d     = duty_q;
      dir_d      = dir_q;
      tgt_duty_d = tgt_duty_q;
      tgt_dir_d  = tgt_dir_q;

      if (estop) begin
         state_d    = S_ESTOP;
         duty_d     = '0;
         tgt_duty_d = '0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_RAMP: begin
               if (tick) begin
                  duty_d = ramp_next;
                  if (ramp_next == tgt_duty_q) state_d = S_IDLE;
               end
            end
            S_REVERSE: begin
               if (duty_q == '0) begin
                  dir_d   = tgt_dir_q;
                  state_d = (tgt_duty_q == '0) ? S_IDLE : S_RAMP;
               end else if (tick) begin
                  duty_d = duty_q - down_amt;
               end
            end
            S_ESTOP: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase

         // A command on a tick edge is judged against the post-step duty/dir, so the step used the old target.
         if (accept) begin
            tgt_dir_d  = cmd_dir;
            tgt_duty_d = cmd_duty_clamped;
            if (cmd_dir != dir_d) begin
               if (duty_d != '0) begin
                  state_d = S_REVERSE;
               end else begin
                  dir_d   = cmd_dir;
                  state_d = (cmd_duty_clamped == '0) ? S_IDLE : S_RAMP;
               end
            end else begin
               state_d = (cmd_duty_clamped == duty_d) ? S_IDLE : S_RAMP;
            end
         end
      end

      enable_d = (duty_d != '0);
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         duty_q     <= '0;
         dir_q      <= 1'b0;
         tgt_duty_q <= '0;
         tgt_dir_q  <= 1'b0;
         enable_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         duty_q     <= duty_d;
         dir_q      <= dir_d;
         tgt_duty_q <= tgt_duty_d;
         tgt_dir_q  <= tgt_dir_d;
         enable_q   <= enable_d;
      end
   end

endmodule

// File: tb/tb_motor_duty_ramp.sv
// tb/tb_motor_duty_ramp.sv - scoreboard bench for motor_duty_ramp
module tb_motor_duty_ramp;
   localparam int PERIOD   = 100;
   localparam int WIDTH    = 12;
   localparam int STEP     = 16;
   localparam int TICK_DIV = 4;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_dir   = 1'b0;
   logic [WIDTH-1:0] cmd_duty  = '0;
   logic             estop     = 1'b0;
   logic             cmd_ready;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] duty_period;
   logic             dir;
   logic             enable;
   logic             at_target;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int duty;
      bit dir;
      bit flip;
   } exp_t;
   exp_t sb[$];

   motor_duty_ramp #(
      .PERIOD(PERIOD), .WIDTH(WIDTH), .STEP(STEP), .TICK_DIV(TICK_DIV)
   ) dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .estop(estop), .period(period),
      .duty_period(duty_period), .dir(dir), .enable(enable), .at_target(at_target)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit (n_vec=%0d)", n_vec);
      $fatal(1);
   end

   task automatic send_cmd(input bit d, input int duty);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_duty  = WIDTH'(duty);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      exp_t             e;
      int               prev;
      int               at;
      logic [WIDTH-1:0] start;
      prev = -1;
      while (sb.size() > 0) begin
         e     = sb.pop_front();
         start = duty_period;
         at    = -1;
         for (int i = 0; i < 3 * TICK_DIV; i++) begin
            @(negedge clk);
            if (duty_period !== start) begin
               at = cyc;
               break;
            end
         end
         n_vec++;
         if (at < 0) begin
            n_err++;
            $display("FAIL %s timeout: duty stuck at %0d, required %0d", tag, duty_period, e.duty);
            sb.delete();
         end else begin
            if (duty_period !== e.duty) begin
               n_err++;
               $display("FAIL %s duty: got %0d, required %0d", tag, duty_period, e.duty);
            end
            n_vec++;
            if (dir !== e.dir) begin
               n_err++;
               $display("FAIL %s dir at duty %0d: got %0b, required %0b", tag, e.duty, dir, e.dir);
            end
            n_vec++;
            if (enable !== (e.duty != 0)) begin
               n_err++;
               $display("FAIL %s enable at duty %0d: got %0b, required %0b", tag, e.duty, enable, (e.duty != 0));
            end
            if (prev >= 0) begin
               n_vec++;
               if (at - prev !== TICK_DIV) begin
                  n_err++;
                  $display("FAIL %s tick gap: got %0d cycles, required %0d", tag, at - prev, TICK_DIV);
               end
            end
            if (e.flip) begin
               @(negedge clk);
               n_vec++;
               if (dir !== !e.dir || duty_period !== 0) begin
                  n_err++;
                  $display("FAIL %s flip after zero: dir %0b duty %0d, required dir %0b duty 0", tag, dir, duty_period, !e.dir);
               end
            end
            prev = at;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (duty_period !== 0 || dir !== 0 || enable !== 0 || period !== 100 || at_target !== 1 || cmd_ready !== 1) begin
         n_err++;
         $display("FAIL reset_state: duty %0d dir %0b en %0b period %0d at %0b rdy %0b", duty_period, dir, enable, period, at_target, cmd_ready);
      end
      send_cmd(1'b1, 40);
      repeat (5) @(negedge clk);
      n_vec++;
      if (duty_period !== 16 || dir !== 1 || enable !== 1) begin
         n_err++;
         $display("FAIL reset_prep: duty %0d dir %0b en %0b, required 16 1 1", duty_period, dir, enable);
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if (duty_period !== 0 || dir !== 0 || enable !== 0 || period !== 100 || at_target !== 1 || cmd_ready !== 1) begin
         n_err++;
         $display("FAIL reset_async: duty %0d dir %0b en %0b period %0d at %0b rdy %0b", duty_period, dir, enable, period, at_target, cmd_ready);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ramp_up();
      send_cmd(1'b0, 50);
      n_vec++;
      if (at_target !== 0) begin
         n_err++;
         $display("FAIL ramp_busy at_target: got %0b, required 0", at_target);
      end
      sb.push_back('{16, 1'b0, 1'b0});
      sb.push_back('{32, 1'b0, 1'b0});
      sb.push_back('{48, 1'b0, 1'b0});
      sb.push_back('{50, 1'b0, 1'b0});
      drain("ramp_up");
      n_vec++;
      if (at_target !== 1) begin
         n_err++;
         $display("FAIL ramp_done at_target: got %0b, required 1", at_target);
      end
   endtask

   task automatic test_reversal();
      send_cmd(1'b1, 30);
      sb.push_back('{34, 1'b0, 1'b0});
      sb.push_back('{18, 1'b0, 1'b0});
      sb.push_back('{2, 1'b0, 1'b0});
      sb.push_back('{0, 1'b0, 1'b1});
      sb.push_back('{16, 1'b1, 1'b0});
      sb.push_back('{30, 1'b1, 1'b0});
      drain("reversal");
      n_vec++;
      if (at_target !== 1) begin
         n_err++;
         $display("FAIL reversal_done at_target: got %0b, required 1", at_target);
      end
   endtask

   task automatic test_clamp_retarget();
      send_cmd(1'b1, 200);
      sb.push_back('{46, 1'b1, 1'b0});
      sb.push_back('{62, 1'b1, 1'b0});
      sb.push_back('{78, 1'b1, 1'b0});
      sb.push_back('{94, 1'b1, 1'b0});
      sb.push_back('{100, 1'b1, 1'b0});
      drain("clamp");
      repeat (2 * TICK_DIV) @(negedge clk);
      n_vec++;
      if (duty_period !== 100 || at_target !== 1) begin
         n_err++;
         $display("FAIL clamp_hold: duty %0d at %0b, required 100 1", duty_period, at_target);
      end
      send_cmd(1'b1, 60);
      sb.push_back('{84, 1'b1, 1'b0});
      sb.push_back('{68, 1'b1, 1'b0});
      sb.push_back('{60, 1'b1, 1'b0});
      drain("retarget");
      repeat (2 * TICK_DIV) @(negedge clk);
      n_vec++;
      if (duty_period !== 60 || at_target !== 1) begin
         n_err++;
         $display("FAIL retarget_hold: duty %0d at %0b, required 60 1", duty_period, at_target);
      end
   endtask

   task automatic test_estop();
      send_cmd(1'b1, 0);
      sb.push_back('{44, 1'b1, 1'b0});
      sb.push_back('{28, 1'b1, 1'b0});
      sb.push_back('{12, 1'b1, 1'b0});
      sb.push_back('{0, 1'b1, 1'b0});
      drain("ramp_down");
      send_cmd(1'b1, 100);
      sb.push_back('{16, 1'b1, 1'b0});
      sb.push_back('{32, 1'b1, 1'b0});
      sb.push_back('{48, 1'b1, 1'b0});
      drain("pre_estop");
      estop     = 1'b1;
      cmd_valid = 1'b1;
      cmd_dir   = 1'b0;
      cmd_duty  = 12'd80;
      @(negedge clk);
      n_vec++;
      if (duty_period !== 0 || enable !== 0 || cmd_ready !== 0 || at_target !== 0) begin
         n_err++;
         $display("FAIL estop_entry: duty %0d en %0b rdy %0b at %0b, required 0 0 0 0", duty_period, enable, cmd_ready, at_target);
      end
      repeat (2 * TICK_DIV) @(negedge clk);
      n_vec++;
      if (duty_period !== 0 || dir !== 1 || cmd_ready !== 0) begin
         n_err++;
         $display("FAIL estop_hold: duty %0d dir %0b rdy %0b, required 0 1 0", duty_period, dir, cmd_ready);
      end
      cmd_valid = 1'b0;
      estop     = 1'b0;
      @(negedge clk);
      n_vec++;
      if (at_target !== 1 || cmd_ready !== 1 || dir !== 1 || duty_period !== 0) begin
         n_err++;
         $display("FAIL estop_release: at %0b rdy %0b dir %0b duty %0d, required 1 1 1 0", at_target, cmd_ready, dir, duty_period);
      end
      repeat (2 * TICK_DIV) @(negedge clk);
      n_vec++;
      if (duty_period !== 0) begin
         n_err++;
         $display("FAIL estop_after: duty %0d, required 0", duty_period);
      end
   endtask

   task automatic test_tick_collision();
      send_cmd(1'b1, 50);
      sb.push_back('{16, 1'b1, 1'b0});
      sb.push_back('{32, 1'b1, 1'b0});
      drain("collide_pre");
      repeat (TICK_DIV - 1) @(negedge clk);
      send_cmd(1'b1, 20);
      n_vec++;
      if (duty_period !== 48) begin
         n_err++;
         $display("FAIL collide_step: duty %0d, required 48 (old target)", duty_period);
      end
      sb.push_back('{32, 1'b1, 1'b0});
      sb.push_back('{20, 1'b1, 1'b0});
      drain("collide_post");
      n_vec++;
      if (at_target !== 1) begin
         n_err++;
         $display("FAIL collide_done at_target: got %0b, required 1", at_target);
      end
   endtask

   task automatic test_zero_reverse();
      send_cmd(1'b0, 0);
      sb.push_back('{4, 1'b1, 1'b0});
      sb.push_back('{0, 1'b1, 1'b1});
      drain("rev_to_zero");
      n_vec++;
      if (at_target !== 1 || dir !== 0) begin
         n_err++;
         $display("FAIL rev_to_zero_done: at %0b dir %0b, required 1 0", at_target, dir);
      end
      send_cmd(1'b1, 0);
      n_vec++;
      if (dir !== 1 || at_target !== 1 || duty_period !== 0 || enable !== 0) begin
         n_err++;
         $display("FAIL flip_at_zero: dir %0b at %0b duty %0d en %0b, required 1 1 0 0", dir, at_target, duty_period, enable);
      end
      send_cmd(1'b1, 0);
      n_vec++;
      if (at_target !== 1 || dir !== 1) begin
         n_err++;
         $display("FAIL same_target: at %0b dir %0b, required 1 1", at_target, dir);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_reversal();
      test_clamp_retarget();
      test_estop();
      test_tick_collision();
      test_zero_reverse();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/motor_duty_ramp.md
# motor_duty_ramp

Soft-start/soft-reverse command stage directly upstream of the motor controller instances. Accepts target (direction, duty) commands over a valid/ready handshake. Slews the duty count toward the target at a fixed rate. Drives the controller's direction, enable, period and duty-period inputs. A reversal always ramps duty to zero before the direction bit flips, so the H-bridge never sees a hard reversal.

## Interface
- PERIOD, 2777 — PWM period in CLOCK_50 cycles (18 kHz); driven constant on `period`.
- WIDTH, 12 — width of the period/duty buses; must hold PERIOD.
- STEP, 16 — maximum duty change per ramp tick.
- TICK_DIV, 5000 — CLOCK_50 cycles per ramp tick (100 us).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high at a rising edge.
- cmd_dir  in  1  target direction.
- cmd_duty  in  WIDTH  target duty count; values above PERIOD are clamped to PERIOD.
- estop  in  1  emergency stop, level-sensitive.
- period  out  WIDTH  constant PERIOD.
- duty_period  out  WIDTH  current duty count, registered.
- dir  out  1  current direction, registered.
- enable  out  1  high iff duty_period != 0.
- at_target  out  1  high iff state == IDLE.

## Operation
- Registers:
  - target_duty, target_dir: the latched command.
  - duty_period, dir: the current outputs.
  - tick counter, 0..TICK_DIV-1.
  - state: IDLE, RAMP, REVERSE or ESTOP.
- Reset values:
  - duty_period = 0, dir = 0, enable = 0, period = PERIOD.
  - target_duty = 0, target_dir = 0, tick counter = 0.
  - state = IDLE, so at_target = 1 and cmd_ready = 1.
- The tick counter runs freely. A tick is the cycle in which the counter equals TICK_DIV-1; the counter wraps to 0 on the following edge.
- cmd_ready = (state != ESTOP), combinational from state.
- Command acceptance:
  - Latch target_dir = cmd_dir and target_duty = min(cmd_duty, PERIOD).
  - If cmd_dir != dir and duty_period != 0, go to REVERSE.
  - Else, if cmd_dir != dir and duty_period == 0, set dir = cmd_dir, then go to RAMP, or to IDLE if the target equals 0.
  - Else, go to RAMP, or to IDLE if target_duty == duty_period.
  - A command accepted in RAMP or REVERSE replaces the pending target. If the new direction equals dir, REVERSE exits to RAMP.
- RAMP, on each tick:
  - duty_period moves toward target_duty by min(STEP, |target_duty - duty_period|), with no overshoot.
  - Compute the difference at WIDTH+1 bits.
  - Go to IDLE on the edge where duty_period becomes equal to target_duty.
- REVERSE, on each tick:
  - duty_period decreases by min(STEP, duty_period).
  - In the cycle after duty_period reaches 0, dir takes target_dir and the state becomes RAMP, or IDLE if target_duty == 0.
- ESTOP:
  - Entered from any state on the first edge where estop is high.
  - duty_period is set to 0 and target_duty is cleared to 0; dir is held.
  - Commands are ignored (cmd_ready = 0).
  - On the first edge with estop low, the state becomes IDLE.
- Simultaneous events:
  - estop has priority over a command and over a tick.
  - A command accepted on a tick edge: that tick's step uses the old target and state. The new target takes effect from the next tick.

## Timing
- Command to first duty change: from 1 to TICK_DIV cycles, depending on the tick phase. Reversal adds ceil(duty/STEP) ticks plus 1 cycle.
- estop to duty_period = 0 and enable = 0: 1 edge.
- The tick phase is not reset by commands; only RESET_N resets it.
- Assertion of RESET_N mid-ramp immediately forces all reset values, without waiting for a clock edge.
- All outputs are glitch-free: registered, or decoded from registered state.

## Test plan
Use PERIOD=100, STEP=16, TICK_DIV=4.
- Reset: pulse RESET_N low between clock edges -> outputs go to duty_period=0, dir=0, enable=0, period=100, at_target=1, cmd_ready=1 with no clock edge.
- Ramp up: command dir=0, duty=50 -> duty_period reads 16, 32, 48, 50 on four consecutive ticks; at_target=1 after the 50; enable goes high with the 16.
- Reversal: from (dir=0, duty=50), command dir=1, duty=30 -> 34, 18, 2, 0; dir flips the cycle after 0; then 16, 30; dir never changes while duty is nonzero.
- Clamp and retarget: command duty=200 -> ramp stops at 100. Then command 60 during the ramp -> descends in steps of 16 to exactly 60, no overshoot.
- Estop: assert estop during a ramp at duty=48 -> next edge duty=0, enable=0, cmd_ready=0; cmd_valid is ignored. On release -> IDLE, dir unchanged, duty stays 0.
- Tick collision: accept a command on the same edge as a tick -> that step uses the old target, and the new target is applied on the next tick.
